// File: rtl/ds1302_time_reader.sv
// rtl/ds1302_time_reader.sv - DS1302 3-wire time poller with BCD decode (optional 12-hour decode: DS1302_HR12_EN)
module ds1302_time_reader #(
  parameter int CLK_DIV     = 25,
  parameter int POLL_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       ce,
  output logic       sclk,
  output logic       io_out,
  output logic       io_oe,
  input  logic       io_in,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       ch,
  output logic       valid,
  output logic       err
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam logic [CW-1:0] HALF       = CW'(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PHASE_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CE_SETUP, S_CMD, S_READ, S_CE_HOLD, S_GAP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    reg_idx;
  logic [PW-1:0] poll_cnt;
  logic [7:0]    rx;
  logic [7:0]    sec_b, min_b, hr_b;
  logic [7:0]    cmd_byte;
  logic          phase_end, trigger, frame_end;

  logic [5:0] sec_bin, min_bin, hr_bin;
  logic       sec_ok, min_ok, hr_ok, frame_ok;
  logic       unused_bits;

  // Register address walks 0x81, 0x83, 0x85 as reg_idx steps seconds, minutes, hours.
  assign cmd_byte  = {5'b10000, reg_idx, 1'b1};
  assign phase_end = (cnt == PHASE_LAST);
  // DONE behaves like IDLE for triggers since busy is already low there.
  assign trigger   = ((state == S_IDLE) || (state == S_DONE)) &&
                     (start || (poll_cnt == POLL_LAST));
  assign frame_end = (state == S_GAP) && phase_end && (reg_idx == 2'd2);

  assign sec_bin = {3'd0, sec_b[6:4]} * 6'd10 + {2'd0, sec_b[3:0]};
  assign min_bin = {3'd0, min_b[6:4]} * 6'd10 + {2'd0, min_b[3:0]};
  assign sec_ok  = (sec_b[3:0] <= 4'd9) && (sec_b[6:4] <= 3'd5);
  assign min_ok  = (min_b[3:0] <= 4'd9) && (min_b[6:4] <= 3'd5);
  assign frame_ok = sec_ok && min_ok && hr_ok;
  assign unused_bits = ^{hr_b[6], min_b[7]};

`ifdef DS1302_HR12_EN
  logic [5:0] h12;
  assign h12 = (hr_b[4] ? 6'd10 : 6'd0) + {2'd0, hr_b[3:0]};
`endif

  // Hours decode: 24-hour form by default, 12-hour form only when the feature is built in.
  always_comb begin
    hr_bin = {4'd0, hr_b[5:4]} * 6'd10 + {2'd0, hr_b[3:0]};
    hr_ok  = (hr_b[3:0] <= 4'd9) && (hr_bin <= 6'd23);
    if (hr_b[7]) begin
`ifdef DS1302_HR12_EN
      if (h12 == 6'd12) hr_bin = hr_b[5] ? 6'd12 : 6'd0;
      else              hr_bin = hr_b[5] ? h12 + 6'd12 : h12;
      hr_ok = (hr_b[3:0] <= 4'd9) && (h12 != 6'd0) && (h12 <= 6'd12);
`else
      hr_ok = 1'b0;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state sequencing through the three transactions of a frame.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: state_n = trigger ? S_CE_SETUP : S_IDLE;
      S_CE_SETUP:     if (phase_end) state_n = S_CMD;
      S_CMD:          if (phase_end && bit_idx == 3'd7) state_n = S_READ;
      S_READ:         if (phase_end && bit_idx == 3'd7) state_n = S_CE_HOLD;
      S_CE_HOLD:      if (phase_end) state_n = S_GAP;
      S_GAP:          if (phase_end) state_n = (reg_idx == 2'd2) ? S_DONE : S_CE_SETUP;
      default:        state_n = S_IDLE;
    endcase
  end

  // Pin and status outputs, decoded from state and phase position.
  always_comb begin
    busy   = 1'b1;
    ce     = 1'b0;
    sclk   = 1'b0;
    io_oe  = 1'b0;
    io_out = 1'b0;
    valid  = 1'b0;
    err    = 1'b0;
    case (state)
      S_IDLE:     busy = 1'b0;
      S_DONE: begin
        busy  = 1'b0;
        valid = frame_ok;
        err   = !frame_ok;
      end
      S_CE_SETUP, S_CE_HOLD: ce = 1'b1;
      S_CMD: begin
        ce     = 1'b1;
        sclk   = (cnt >= HALF);
        io_oe  = 1'b1;
        io_out = cmd_byte[bit_idx];
      end
      S_READ: begin
        ce   = 1'b1;
        sclk = (cnt >= HALF);
      end
      default: ce = 1'b0;
    endcase
  end

  // Phase, bit and register counters; all restart whenever the frame is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      reg_idx <= '0;
    end else if ((state == S_IDLE) || (state == S_DONE)) begin
      cnt     <= '0;
      bit_idx <= '0;
      reg_idx <= '0;
    end else begin
      cnt <= phase_end ? '0 : cnt + CW'(1);
      if (((state == S_CMD) || (state == S_READ)) && phase_end) bit_idx <= bit_idx + 3'd1;
      if ((state == S_GAP) && phase_end) reg_idx <= reg_idx + 2'd1;
    end
  end

  // Poll counter runs through frames so the poll period is measured trigger to trigger.
  always_ff @(posedge clk) begin
    if (rst)                       poll_cnt <= '0;
    else if (trigger)              poll_cnt <= '0;
    else if (poll_cnt != POLL_LAST) poll_cnt <= poll_cnt + PW'(1);
  end

  // Sample io_in just before each rising sclk and park finished bytes per register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx    <= '0;
      sec_b <= '0;
      min_b <= '0;
      hr_b  <= '0;
    end else if (state == S_READ) begin
      if (cnt == HALF_LAST) rx[bit_idx] <= io_in;
      if (phase_end && bit_idx == 3'd7) begin
        case (reg_idx)
          2'd0:    sec_b <= rx;
          2'd1:    min_b <= rx;
          default: hr_b  <= rx;
        endcase
      end
    end
  end

  // Publish all fields together on entry to DONE, only when the frame validated.
  always_ff @(posedge clk) begin
    if (rst) begin
      hr  <= '0;
      min <= '0;
      sec <= '0;
      ch  <= 1'b0;
    end else if (frame_end && frame_ok) begin
      hr  <= hr_bin[4:0];
      min <= min_bin;
      sec <= sec_bin;
      ch  <= sec_b[7];
    end
  end

endmodule

// File: tb/tb_ds1302_time_reader.sv
// tb/tb_ds1302_time_reader.sv - randomized self-checking bench for ds1302_time_reader
module tb_ds1302_time_reader;

  localparam int CLK_DIV = 3;
  localparam int POLL    = 500;
  localparam int LAT     = 114 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       io_in = 1'b0;
  logic       busy, ce, sclk, io_out, io_oe, ch, valid, err;
  logic [4:0] hr;
  logic [5:0] min, sec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // RTC model state
  logic [7:0] rtc_sec = 8'h00, rtc_min = 8'h00, rtc_hr = 8'h00;
  logic [7:0] m_cmd = 8'h00;
  logic       m_prev_sclk = 1'b0;
  int         m_bits = 0;
  int         oe_bad = 0;
  logic [7:0] cmd_q[$];

  // expected published values
  int exp_h = 0, exp_m = 0, exp_s = 0;
  bit exp_c = 0;

  ds1302_time_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .ce(ce), .sclk(sclk),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .hr(hr), .min(min), .sec(sec),
    .ch(ch), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DS1302: shifts in a command on rising sclk, answers on falling sclk.
  always @(negedge clk) begin
    logic [7:0] rd;
    if (!ce) begin
      m_bits = 0;
      m_cmd  = 8'h00;
    end else begin
      if (sclk && !m_prev_sclk) begin
        if (m_bits < 8) begin
          m_cmd[m_bits] = io_out;
          if (!io_oe) oe_bad++;
          if (m_bits == 7) cmd_q.push_back(m_cmd);
        end else if (io_oe) oe_bad++;
        m_bits++;
      end
      if (!sclk && m_prev_sclk && m_bits >= 8 && m_bits < 16) begin
        if (io_oe) oe_bad++;
        case (m_cmd)
          8'h81:   rd = rtc_sec;
          8'h83:   rd = rtc_min;
          8'h85:   rd = rtc_hr;
          default: rd = 8'h00;
        endcase
        io_in = rd[m_bits - 8];
      end
    end
    m_prev_sclk = sclk;
  end

  // Reference decode from the register definitions using digit arithmetic.
  function automatic void ref_decode(input logic [7:0] sb, input logic [7:0] mb, input logic [7:0] hb,
                                     output bit ok, output int h, output int m, output int s, output bit c);
    int su, st, mu, mt, hu;
    su = int'(sb) % 16;  st = (int'(sb) / 16) % 8;
    mu = int'(mb) % 16;  mt = (int'(mb) / 16) % 8;
    s  = 10 * st + su;   m  = 10 * mt + mu;
    c  = sb[7];
    ok = (su < 10) && (st < 6) && (mu < 10) && (mt < 6);
    hu = int'(hb) % 16;
    if (hb[7]) begin
`ifdef DS1302_HR12_EN
      int tw, pm;
      tw = 10 * ((int'(hb) / 16) % 2) + hu;
      pm = (int'(hb) / 32) % 2;
      h  = (tw % 12) + 12 * pm;
      if (hu > 9 || tw < 1 || tw > 12) ok = 0;
`else
      h  = 0;
      ok = 0;
`endif
    end else begin
      h = 10 * ((int'(hb) / 16) % 4) + hu;
      if (hu > 9 || h > 23) ok = 0;
    end
  endfunction

  // Runs one start-triggered frame and reports what the DUT did.
  task automatic do_frame(input logic [7:0] sb, input logic [7:0] mb, input logic [7:0] hb,
                          output int lat, output logic got_v, output logic got_e,
                          output logic busy_at, output logic hold_next);
    rtc_sec = sb; rtc_min = mb; rtc_hr = hb;
    cmd_q.delete();
    oe_bad = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(valid || err) && lat < 2000);
    got_v = valid; got_e = err; busy_at = busy;
    @(posedge clk); #1;
    hold_next = valid | err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({ce, sclk, io_oe, io_out, busy, valid, err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_pins got=%b want=0000000", {ce, sclk, io_oe, io_out, busy, valid, err});
    end
    checks++;
    if ({hr, min, sec, ch} !== 18'd0) begin
      failures++;
      $display("FAIL reset_fields got hr=%0d min=%0d sec=%0d ch=%0d want all 0", hr, min, sec, ch);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_basic();
    int lat; logic v, e, b, hn;
    do_frame(8'h45, 8'h59, 8'h23, lat, v, e, b, hn);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
    checks++;
    if ({v, e, b, hn} !== 4'b1000) begin
      failures++; $display("FAIL basic_pulse got valid=%b err=%b busy=%b next=%b want 1 0 0 0", v, e, b, hn);
    end
    checks++;
    if (cmd_q.size() != 3) begin
      failures++; $display("FAIL basic_cmd_count got=%0d want=3", cmd_q.size());
    end else begin
      checks++;
      if ({cmd_q[0], cmd_q[1], cmd_q[2]} !== 24'h818385) begin
        failures++; $display("FAIL basic_cmds got=%h %h %h want=81 83 85", cmd_q[0], cmd_q[1], cmd_q[2]);
      end
    end
    checks++;
    if (oe_bad != 0) begin failures++; $display("FAIL basic_io_oe got=%0d violations want=0", oe_bad); end
    checks++;
    if ({hr, min, sec, ch} !== {5'd23, 6'd59, 6'd45, 1'b0}) begin
      failures++; $display("FAIL basic_fields got hr=%0d min=%0d sec=%0d ch=%0d want 23 59 45 0", hr, min, sec, ch);
    end
    exp_h = 23; exp_m = 59; exp_s = 45; exp_c = 0;
  endtask

  task automatic test_ch();
    int lat; logic v, e, b, hn;
    do_frame(8'hC5, 8'h30, 8'h07, lat, v, e, b, hn);
    checks++;
    if ({v, e} !== 2'b10) begin failures++; $display("FAIL ch_pulse got valid=%b err=%b want 1 0", v, e); end
    checks++;
    if ({hr, min, sec, ch} !== {5'd7, 6'd30, 6'd45, 1'b1}) begin
      failures++; $display("FAIL ch_fields got hr=%0d min=%0d sec=%0d ch=%0d want 7 30 45 1", hr, min, sec, ch);
    end
    exp_h = 7; exp_m = 30; exp_s = 45; exp_c = 1;
  endtask

  task automatic test_bad_min();
    int lat; logic v, e, b, hn;
    do_frame(8'h12, 8'h34, 8'h23, lat, v, e, b, hn);
    do_frame(8'h05, 8'h7A, 8'h11, lat, v, e, b, hn);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL badmin_latency got=%0d want=%0d", lat, LAT); end
    checks++;
    if ({v, e, hn} !== 3'b010) begin
      failures++; $display("FAIL badmin_pulse got valid=%b err=%b next=%b want 0 1 0", v, e, hn);
    end
    checks++;
    if ({hr, min, sec, ch} !== {5'd23, 6'd34, 6'd12, 1'b0}) begin
      failures++; $display("FAIL badmin_hold got hr=%0d min=%0d sec=%0d ch=%0d want 23 34 12 0", hr, min, sec, ch);
    end
    exp_h = 23; exp_m = 34; exp_s = 12; exp_c = 0;
  endtask

  task automatic test_hr_mode();
    logic [7:0] hb[4];
    bit okv[4];
    int hv[4];
    int lat; logic v, e, b, hn;
    hb = '{8'h92, 8'hB2, 8'hA5, 8'h80};
`ifdef DS1302_HR12_EN
    okv = '{1, 1, 1, 0};
    hv  = '{0, 12, 17, 0};
`else
    okv = '{0, 0, 0, 0};
    hv  = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      do_frame(8'h10, 8'h20, hb[i], lat, v, e, b, hn);
      if (okv[i]) begin exp_h = hv[i]; exp_m = 20; exp_s = 10; exp_c = 0; end
      checks++;
      if ({v, e} !== {okv[i], !okv[i]}) begin
        failures++; $display("FAIL hr_mode_pulse byte=%h got valid=%b err=%b want %b %b", hb[i], v, e, okv[i], !okv[i]);
      end
      checks++;
      if ({hr, min, sec} !== {5'(exp_h), 6'(exp_m), 6'(exp_s)}) begin
        failures++; $display("FAIL hr_mode_fields byte=%h got hr=%0d min=%0d sec=%0d want %0d %0d %0d",
                             hb[i], hr, min, sec, exp_h, exp_m, exp_s);
      end
    end
  endtask

  task automatic test_poll();
    int t0, t1, nv, vn, k;
    rtc_sec = 8'h01; rtc_min = 8'h02; rtc_hr = 8'h03;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL poll_busy_rise got=%b want=1", busy); end
    nv = 0; vn = -1;
    for (int n = 1; n <= LAT + 5; n++) begin
      @(posedge clk); #1;
      if (valid || err) begin nv++; if (vn < 0) vn = n; end
      if (n == 100) start = 1'b1;
      if (n == 101) start = 1'b0;
    end
    checks++;
    if (nv != 1 || vn != LAT) begin
      failures++; $display("FAIL poll_midframe_start got pulses=%0d at=%0d want 1 at %0d", nv, vn, LAT);
    end
    k = 0;
    while (!busy && k < 1000) begin @(posedge clk); #1; k++; end
    t1 = cyc;
    checks++;
    if (t1 - t0 != POLL) begin failures++; $display("FAIL poll_period got=%0d want=%0d", t1 - t0, POLL); end
    k = 0;
    while (!(valid || err) && k < 1000) begin @(posedge clk); #1; k++; end
    checks++;
    if (valid !== 1'b1 || {hr, min, sec} !== {5'd3, 6'd2, 6'd1}) begin
      failures++; $display("FAIL poll_auto_frame got valid=%b hr=%0d min=%0d sec=%0d want 1 3 2 1", valid, hr, min, sec);
    end
    exp_h = 3; exp_m = 2; exp_s = 1; exp_c = 0;
  endtask

  task automatic test_reset_midframe();
    int k, lat; logic v, e, b, hn;
    rtc_sec = 8'h33; rtc_min = 8'h44; rtc_hr = 8'h15;
    cmd_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (cmd_q.size() < 2 && k < 1000) begin @(posedge clk); #1; k++; end
    checks++;
    if (cmd_q.size() < 2) begin failures++; $display("FAIL rstmid_reach got cmds=%0d want>=2", cmd_q.size()); end
    repeat (6 * CLK_DIV) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if ({ce, sclk, io_oe, busy, valid, err} !== 6'b0) begin
      failures++; $display("FAIL rstmid_pins got=%b want=000000", {ce, sclk, io_oe, busy, valid, err});
    end
    checks++;
    if ({hr, min, sec, ch} !== 18'd0) begin
      failures++; $display("FAIL rstmid_fields got hr=%0d min=%0d sec=%0d ch=%0d want 0", hr, min, sec, ch);
    end
    do_frame(8'h33, 8'h44, 8'h15, lat, v, e, b, hn);
    checks++;
    if (lat !== LAT || v !== 1'b1 || {hr, min, sec} !== {5'd15, 6'd44, 6'd33}) begin
      failures++; $display("FAIL rstmid_recover got lat=%0d valid=%b hr=%0d min=%0d sec=%0d want %0d 1 15 44 33",
                           lat, v, hr, min, sec, LAT);
    end
    exp_h = 15; exp_m = 44; exp_s = 33; exp_c = 0;
  endtask

  task automatic test_random();
    logic [7:0] sb, mb, hb;
    int v, lat, rh, rm, rs;
    bit ok, rc;
    logic gv, ge, gb, hn;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(3, 0) == 0) sb = 8'($urandom);
      else begin v = $urandom_range(59, 0); sb = 8'((v / 10) * 16 + v % 10); sb[7] = 1'($urandom_range(1, 0)); end
      if ($urandom_range(3, 0) == 0) mb = 8'($urandom);
      else begin v = $urandom_range(59, 0); mb = 8'((v / 10) * 16 + v % 10); end
      if ($urandom_range(3, 0) == 0) hb = 8'($urandom);
      else if ($urandom_range(1, 0) == 0) begin
        v = $urandom_range(12, 1);
        hb = 8'(128 + 32 * $urandom_range(1, 0) + (v / 10) * 16 + v % 10);
      end else begin v = $urandom_range(23, 0); hb = 8'((v / 10) * 16 + v % 10); end
      ref_decode(sb, mb, hb, ok, rh, rm, rs, rc);
      if (ok) begin exp_h = rh; exp_m = rm; exp_s = rs; exp_c = rc; end
      do_frame(sb, mb, hb, lat, gv, ge, gb, hn);
      checks++;
      if (lat !== LAT || {gv, ge, gb} !== {ok, !ok, 1'b0} || oe_bad != 0) begin
        failures++; $display("FAIL rand_pulse bytes=%h %h %h got lat=%0d valid=%b err=%b busy=%b oe_bad=%0d want %0d %b %b 0 0",
                             sb, mb, hb, lat, gv, ge, gb, oe_bad, LAT, ok, !ok);
      end
      checks++;
      if ({hr, min, sec, ch} !== {5'(exp_h), 6'(exp_m), 6'(exp_s), exp_c}) begin
        failures++; $display("FAIL rand_fields bytes=%h %h %h got hr=%0d min=%0d sec=%0d ch=%0d want %0d %0d %0d %0d",
                             sb, mb, hb, hr, min, sec, ch, exp_h, exp_m, exp_s, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ch();
    test_bad_min();
    test_hr_mode();
    test_poll();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
